// File: rtl/pwl_activation_unit.sv
// Piecewise-linear activation: writable breakpoint table, segment select on the
// upper input bits, 3-stage interpolation pipeline with a global stall.
module pwl_activation_unit #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4,
    parameter int ROUND  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_y,
    input  logic                     tbl_we,
    input  logic        [IDX_W-1:0]  tbl_addr,
    input  logic signed [DATA_W-1:0] tbl_data
);
    localparam int FRAC_W = DATA_W - IDX_W;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int PW     = DATA_W + FRAC_W + 2;
    localparam logic signed [PW-1:0] RND = (ROUND != 0) ? (PW'(1) << (FRAC_W - 1)) : PW'(0);

    logic signed [DATA_W-1:0] tbl [DEPTH];

    logic                     advance;
    logic        [DATA_W-1:0] u;
    logic        [IDX_W-1:0]  idx;
    logic        [IDX_W-1:0]  idx_nx;
    logic        [FRAC_W-1:0] rem;

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_base;
    logic signed [DATA_W-1:0] s1_next;
    logic        [FRAC_W-1:0] s1_rem;
    logic                     s2_valid;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [PW-1:0]     s2_prod;

    logic signed [DATA_W:0]   diff;
    logic signed [PW-1:0]     diff_ext;
    logic signed [PW-1:0]     rem_ext;
    logic signed [PW-1:0]     prod_c;
    logic signed [PW-1:0]     y_full;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Offset-binary view of the input makes the segment index monotonic in x.
    assign u      = {~in_x[DATA_W-1], in_x[DATA_W-2:0]};
    assign idx    = u[DATA_W-1:FRAC_W];
    assign rem    = u[FRAC_W-1:0];
    assign idx_nx = (idx == '1) ? idx : idx + 1'b1;

    always_comb begin
        diff     = {s1_next[DATA_W-1], s1_next} - {s1_base[DATA_W-1], s1_base};
        diff_ext = PW'(diff);
        rem_ext  = PW'(s1_rem);
        prod_c   = diff_ext * rem_ext + RND;
        y_full   = PW'(s2_base) + (s2_prod >>> FRAC_W);
    end

    // Table writes ignore the stall; S1 samples the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_base   <= '0;
            s1_next   <= '0;
            s1_rem    <= '0;
            s2_valid  <= 1'b0;
            s2_base   <= '0;
            s2_prod   <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_base   <= tbl[idx];
            s1_next   <= tbl[idx_nx];
            s1_rem    <= rem;
            s2_valid  <= s1_valid;
            s2_base   <= s1_base;
            s2_prod   <= prod_c;
            out_valid <= s2_valid;
            out_y     <= y_full[DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_pwl_activation_unit.sv
// Directed bench for pwl_activation_unit: a truncating and a rounding instance
// share all inputs; outputs are checked at the falling edge.
module tb_pwl_activation_unit;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_x = '0;
    logic              out_ready = 1'b1;
    logic              tbl_we = 1'b0;
    logic        [3:0] tbl_addr = '0;
    logic signed [7:0] tbl_data = '0;

    logic              in_ready, in_ready_r;
    logic              out_valid, out_valid_r;
    logic signed [7:0] y0, y1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwl_activation_unit #(.DATA_W(8), .IDX_W(4), .ROUND(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(y0),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    pwl_activation_unit #(.DATA_W(8), .IDX_W(4), .ROUND(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .in_x(in_x),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_y(y1),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic signed [7:0] d);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [7:0] x, input int e0, input int e1);
        @(negedge clk);
        in_valid = 1'b1; in_x = x;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_y_trunc"}, y0, e0);
        chk({tag, "_y_round"}, y1, e1);
    endtask

    logic [7:0]        sx [5];
    logic signed [7:0] sy [5];
    logic signed [7:0] held;
    int i, k, stall_left;
    bit stalled;

    initial begin
        sx = '{8'h00, 8'h18, 8'h15, 8'hB8, 8'h7F};
        sy = '{8'sd0, 8'sd30, 8'sd26, 8'sd0, 8'sd77};

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", y0, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        wr(4'd9, 8'sd20);
        wr(4'd10, 8'sd40);

        // back-to-back stream, latency 3
        @(negedge clk); in_valid = 1'b1; in_x = 8'h00;
        @(negedge clk); in_x = 8'h18;
        @(negedge clk); in_x = 8'h15;
        chk("lat_not_early", out_valid, 0);
        @(negedge clk); in_valid = 1'b0;
        chk("s0_valid", out_valid, 1);
        chk("s0_y", y0, 0);
        @(negedge clk);
        chk("s1_valid", out_valid, 1);
        chk("s1_y", y0, 30);
        @(negedge clk);
        chk("s2_valid", out_valid, 1);
        chk("s2_y", y0, 26);
        @(negedge clk);
        chk("s_end_valid", out_valid, 0);

        wr(4'd3, -8'sd100);
        wr(4'd4, 8'sd100);
        run1("wide_diff", 8'hB8, 0, 0);

        wr(4'd6, -8'sd20);
        run1("round", 8'hD5, -7, -6);

        wr(4'd15, 8'sd77);
        run1("top_flat", 8'h7F, 77, 77);

        // backpressure: 4-cycle stall after the first delivered result
        i = 0; k = 0; stall_left = 0; stalled = 0; held = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in_valid = (i < 5);
            in_x = sx[(i < 5) ? i : 0];
            if (k == 1 && !stalled) begin
                stalled = 1; stall_left = 4; held = y0;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (!out_ready) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_valid_held", out_valid, 1);
                chk("bp_y_held", y0, held);
            end
            if (out_valid && out_ready) begin
                if (k < 5) chk($sformatf("bp_order%0d", k), y0, sy[k]);
                else chk("bp_extra", k, 4);
                k++;
            end
            if (in_valid && in_ready) i++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_delivered", k, 5);
        chk("bp_accepted", i, 5);
        chk("bp_stalled", stalled, 1);

        // write hazard: same-cycle write reads the old entry
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = 4'd9; tbl_data = 8'sd50;
        in_valid = 1'b1; in_x = 8'h18;
        @(negedge clk);
        tbl_we = 1'b0; in_x = 8'h18;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("haz_old_valid", out_valid, 1);
        chk("haz_old_y", y0, 30);
        @(negedge clk);
        chk("haz_new_valid", out_valid, 1);
        chk("haz_new_y", y0, 45);

        // reset mid-stream
        @(negedge clk); in_valid = 1'b1; in_x = 8'h18;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", y0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_in_ready", in_ready, 1);
        @(negedge clk);
        chk("mid_no_residue1", out_valid, 0);
        @(negedge clk);
        chk("mid_no_residue2", out_valid, 0);
        run1("cleared", 8'h18, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
